// File: rtl/char_match_engine.sv
// rtl/char_match_engine.sv - sequential Hamming-distance template matcher, one slot per clock
module char_match_engine #(
    parameter int FEAT_W   = 40,
    parameter int NUM_TMPL = 8,
    parameter int IDX_W    = 3,
    parameter int CODE_W   = 8,
    parameter int DIST_W   = 6
) (
    input  logic              pixelclk,
    input  logic              reset_n,
    input  logic              i_tmpl_we,
    input  logic [IDX_W-1:0]  i_tmpl_addr,
    input  logic [FEAT_W-1:0] i_tmpl_data,
    input  logic [CODE_W-1:0] i_tmpl_code,
    input  logic              i_tmpl_clr,
    input  logic              i_start,
    input  logic [FEAT_W-1:0] i_feature,
    input  logic [DIST_W-1:0] i_thresh,
    input  logic [DIST_W-1:0] i_margin,
    output logic              o_busy,
    output logic              o_done,
    output logic [CODE_W-1:0] o_result,
    output logic [IDX_W-1:0]  o_best_idx,
    output logic [DIST_W-1:0] o_best_dist,
    output logic [DIST_W-1:0] o_second_dist,
    output logic              o_reject
);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TMPL - 1);

    state_t              state;
    logic [FEAT_W-1:0]   tmpl [NUM_TMPL];
    logic [CODE_W-1:0]   code [NUM_TMPL];
    logic [NUM_TMPL-1:0] valid;

    logic [FEAT_W-1:0]   feat_q;
    logic [DIST_W-1:0]   thresh_q;
    logic [DIST_W-1:0]   margin_q;
    logic [IDX_W-1:0]    idx;
    logic [DIST_W-1:0]   best;
    logic [DIST_W-1:0]   second;
    logic [IDX_W-1:0]    best_idx_q;
    logic [1:0]          nvalid;

    logic                addr_ok;
    logic [FEAT_W-1:0]   diff;
    logic [DIST_W-1:0]   cur_dist;
    logic [DIST_W-1:0]   gap;
    logic                reject_c;

    // Only an index range wider than the slot count needs an explicit bound check.
    if ((2 ** IDX_W) > NUM_TMPL) begin : g_addr_chk
        assign addr_ok = (int'(i_tmpl_addr) < NUM_TMPL);
    end else begin : g_addr_full
        assign addr_ok = 1'b1;
    end

    always_comb begin
        diff     = feat_q ^ tmpl[idx];
        cur_dist = '0;
        for (int i = 0; i < FEAT_W; i++) begin
            cur_dist = cur_dist + DIST_W'(diff[i]);
        end
    end

    // second >= best always holds, so the gap cannot underflow.
    always_comb begin
        gap      = second - best;
        reject_c = (nvalid == 2'd0) || (best > thresh_q) ||
                   ((nvalid == 2'd2) && (gap < margin_q));
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            valid         <= '0;
            for (int i = 0; i < NUM_TMPL; i++) begin
                tmpl[i] <= '0;
                code[i] <= '0;
            end
            feat_q        <= '0;
            thresh_q      <= '0;
            margin_q      <= '0;
            idx           <= '0;
            best          <= '0;
            second        <= '0;
            best_idx_q    <= '0;
            nvalid        <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_result      <= '0;
            o_best_idx    <= '0;
            o_best_dist   <= '0;
            o_second_dist <= '0;
            o_reject      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_tmpl_clr) begin
                        valid <= '0;
                    end else if (i_tmpl_we && addr_ok) begin
                        valid[i_tmpl_addr] <= 1'b1;
                        tmpl[i_tmpl_addr]  <= i_tmpl_data;
                        code[i_tmpl_addr]  <= i_tmpl_code;
                    end
                    if (i_start) begin
                        feat_q     <= i_feature;
                        thresh_q   <= i_thresh;
                        margin_q   <= i_margin;
                        idx        <= '0;
                        best       <= '1;
                        second     <= '1;
                        best_idx_q <= '0;
                        nvalid     <= '0;
                        o_busy     <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (valid[idx]) begin
                        if (nvalid != 2'd2) begin
                            nvalid <= nvalid + 2'd1;
                        end
                        if (cur_dist < best) begin
                            second     <= best;
                            best       <= cur_dist;
                            best_idx_q <= idx;
                        end else if (cur_dist < second) begin
                            second <= cur_dist;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    o_result      <= reject_c ? '0 : code[best_idx_q];
                    o_best_idx    <= best_idx_q;
                    o_best_dist   <= best;
                    o_second_dist <= second;
                    o_reject      <= reject_c;
                    o_done        <= 1'b1;
                    o_busy        <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_match_engine.sv
// tb/tb_char_match_engine.sv - scoreboard bench for char_match_engine
module tb_char_match_engine;

    logic        pixelclk;
    logic        reset_n;
    logic        i_tmpl_we;
    logic [2:0]  i_tmpl_addr;
    logic [39:0] i_tmpl_data;
    logic [7:0]  i_tmpl_code;
    logic        i_tmpl_clr;
    logic        i_start;
    logic [39:0] i_feature;
    logic [5:0]  i_thresh;
    logic [5:0]  i_margin;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_result;
    logic [2:0]  o_best_idx;
    logic [5:0]  o_best_dist;
    logic [5:0]  o_second_dist;
    logic        o_reject;

    char_match_engine dut (
        .pixelclk      (pixelclk),
        .reset_n       (reset_n),
        .i_tmpl_we     (i_tmpl_we),
        .i_tmpl_addr   (i_tmpl_addr),
        .i_tmpl_data   (i_tmpl_data),
        .i_tmpl_code   (i_tmpl_code),
        .i_tmpl_clr    (i_tmpl_clr),
        .i_start       (i_start),
        .i_feature     (i_feature),
        .i_thresh      (i_thresh),
        .i_margin      (i_margin),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_best_idx    (o_best_idx),
        .o_best_dist   (o_best_dist),
        .o_second_dist (o_second_dist),
        .o_reject      (o_reject)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [2:0] idx;
        logic [5:0] best;
        logic [5:0] second;
        logic       rej;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   push_cnt  = 0;
    int   last_done = 0;
    int   prev_done = 0;

    initial begin
        pixelclk = 1'b0;
        forever #5 pixelclk = ~pixelclk;
    end

    always @(posedge pixelclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, required end before 200000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge pixelclk) begin
        if (o_done) begin
            exp_t e;
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got o_done at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result",      64'(o_result),      64'(e.res));
                chk("best_idx",    64'(o_best_idx),    64'(e.idx));
                chk("best_dist",   64'(o_best_dist),   64'(e.best));
                chk("second_dist", 64'(o_second_dist), 64'(e.second));
                chk("reject",      64'(o_reject),      64'(e.rej));
            end
        end
    end

    task automatic push(input logic [7:0] res, input logic [2:0] idx,
                        input logic [5:0] best, input logic [5:0] second, input logic rej);
        exp_t e;
        e.res = res; e.idx = idx; e.best = best; e.second = second; e.rej = rej;
        exp_q.push_back(e);
        push_cnt++;
    endtask

    task automatic write_tmpl(input logic [2:0] a, input logic [39:0] d, input logic [7:0] c);
        i_tmpl_we = 1'b1; i_tmpl_addr = a; i_tmpl_data = d; i_tmpl_code = c;
        @(posedge pixelclk); #1;
        i_tmpl_we = 1'b0;
    endtask

    task automatic start_match(input logic [39:0] f, input logic [5:0] t, input logic [5:0] m);
        i_feature = f; i_thresh = t; i_margin = m; i_start = 1'b1;
        @(posedge pixelclk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int n = 0;
        do begin
            @(posedge pixelclk); #1;
            n++;
        end while (!o_done && n < 30);
        chk(name, 64'(n), 64'(exp_cycles));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},   64'(o_busy),        64'd0);
        chk({tag, "_done"},   64'(o_done),        64'd0);
        chk({tag, "_result"}, 64'(o_result),      64'd0);
        chk({tag, "_idx"},    64'(o_best_idx),    64'd0);
        chk({tag, "_best"},   64'(o_best_dist),   64'd0);
        chk({tag, "_second"}, 64'(o_second_dist), 64'd0);
        chk({tag, "_reject"}, 64'(o_reject),      64'd0);
    endtask

    initial begin
        reset_n = 1'b0; i_tmpl_we = 1'b0; i_tmpl_addr = '0; i_tmpl_data = '0;
        i_tmpl_code = '0; i_tmpl_clr = 1'b0; i_start = 1'b0; i_feature = '0;
        i_thresh = '0; i_margin = '0;
        repeat (3) @(posedge pixelclk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge pixelclk); #1;

        // Distinct one-hot patterns: the matched slot is 0 away, every other slot 2 away.
        for (int i = 0; i < 8; i++) write_tmpl(3'(i), 40'h1 << i, 8'h30 + 8'(i));
        push(8'h35, 3'd5, 6'd0, 6'd2, 1'b0);
        start_match(40'h1 << 5, 6'd10, 6'd0);
        wait_done("latency_basic", 9);

        for (int i = 0; i < 8; i++) write_tmpl(3'(i), 40'h1F, 8'h30 + 8'(i));
        write_tmpl(3'd2, 40'h7, 8'h32);
        write_tmpl(3'd6, 40'h7000, 8'h36);
        push(8'h32, 3'd2, 6'd3, 6'd3, 1'b0);
        start_match(40'h0, 6'd10, 6'd0);
        wait_done("latency_tie", 9);
        push(8'h00, 3'd2, 6'd3, 6'd3, 1'b1);
        start_match(40'h0, 6'd10, 6'd1);
        wait_done("latency_tie_margin", 9);

        write_tmpl(3'd0, 40'hFFF, 8'h30);
        for (int i = 1; i < 8; i++) write_tmpl(3'(i), 40'hFFFF, 8'h30 + 8'(i));
        push(8'h00, 3'd0, 6'd12, 6'd16, 1'b1);
        start_match(40'h0, 6'd11, 6'd0);
        wait_done("latency_thr11", 9);
        push(8'h30, 3'd0, 6'd12, 6'd16, 1'b0);
        start_match(40'h0, 6'd12, 6'd0);
        wait_done("latency_thr12", 9);

        i_tmpl_clr = 1'b1;
        @(posedge pixelclk); #1;
        i_tmpl_clr = 1'b0;
        push(8'h00, 3'd0, 6'd63, 6'd63, 1'b1);
        start_match(40'h0, 6'd10, 6'd0);
        wait_done("latency_empty", 9);
        write_tmpl(3'd7, 40'h3, 8'h37);
        push(8'h37, 3'd7, 6'd2, 6'd63, 1'b0);
        start_match(40'h0, 6'd10, 6'd5);
        wait_done("latency_single", 9);

        // A start and a slot-3 write issued mid-scan must both be dropped.
        push(8'h37, 3'd7, 6'd2, 6'd63, 1'b0);
        start_match(40'h0, 6'd10, 6'd5);
        repeat (3) @(posedge pixelclk);
        #1;
        i_start = 1'b1; i_tmpl_we = 1'b1; i_tmpl_addr = 3'd3;
        i_tmpl_data = 40'h0; i_tmpl_code = 8'h99;
        @(posedge pixelclk); #1;
        i_start = 1'b0; i_tmpl_we = 1'b0;
        wait_done("latency_busy", 5);
        push(8'h37, 3'd7, 6'd2, 6'd63, 1'b0);
        start_match(40'h0, 6'd10, 6'd5);
        wait_done("latency_b2b", 9);
        @(negedge pixelclk); #1;
        chk("b2b_gap", 64'(last_done - prev_done), 64'd10);
        repeat (12) @(posedge pixelclk);
        #1;

        start_match(40'h0, 6'd10, 6'd0);
        repeat (4) @(posedge pixelclk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge pixelclk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge pixelclk);
        #1;
        push(8'h00, 3'd0, 6'd63, 6'd63, 1'b1);
        start_match(40'h0, 6'd10, 6'd0);
        wait_done("latency_post_reset", 9);
        @(negedge pixelclk); #1;

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_count",  64'(done_cnt),     64'(push_cnt));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
